ece571f23_g5_aes_loader: RTL and testbench

- Word-serial front/back end for the combinational AES-128 cipher.
- Collects 32-bit key and plaintext words and drives stable 128-bit key/plaintext buses into the cipher.
- Waits a fixed settle window for the multicycle combinational path, captures the ciphertext, then streams it out as four 32-bit words.
- Sits directly upstream of the cipher, feeding it, and also consumes its output.

---
 rtl/ece571f23_g5_aes_pkg.sv | 16 +
 rtl/ece571f23_g5_aes_wordpacker.sv | 27 ++
 rtl/ece571f23_g5_aes_loader.sv | 157 +++++++++++++++
 tb/tb_ece571f23_g5_aes_loader.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/ece571f23_g5_aes_pkg.sv
// Shared widths and FSM state type for the word-serial AES-128 loader.
package ece571f23_g5_aes_pkg;

    localparam int unsigned WORD_W    = 32;
    localparam int unsigned BLK_W     = 128;
    localparam int unsigned BLK_WORDS = 4;
    localparam int unsigned WCNT_W    = 2;
    localparam int unsigned SCNT_W    = 4;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        SETTLE  = 2'd1,
        DRAIN   = 2'd2
    } loader_state_t;

endpackage

// File: rtl/ece571f23_g5_aes_wordpacker.sv
// Packs four 32-bit words, most-significant first, into a 128-bit block.
module ece571f23_g5_aes_wordpacker
    import ece571f23_g5_aes_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [WORD_W-1:0] data,
    output logic [BLK_W-1:0]  block,
    output logic [WCNT_W-1:0] cnt,
    output logic              wrap_c
);

    // The word completing a block is the one loaded while the counter sits at its last slot.
    assign wrap_c = load && (cnt == WCNT_W'(BLK_WORDS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            block <= '0;
            cnt   <= '0;
        end else if (load) begin
            block <= {block[BLK_W-WORD_W-1:0], data};
            cnt   <= cnt + WCNT_W'(1);
        end
    end

endmodule

// File: rtl/ece571f23_g5_aes_loader.sv
// Word-serial front/back end for a combinational AES-128 cipher.
// Optional CBC chaining (IV = 0) is enabled by defining AES_LOADER_CBC_EN.
module ece571f23_g5_aes_loader
    import ece571f23_g5_aes_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    input  logic              key_load,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_data,
    output logic [BLK_W-1:0]  plaintext,
    output logic [BLK_W-1:0]  key,
    input  logic [BLK_W-1:0]  cipher,
    output logic              busy
);

    loader_state_t     state, state_n;
    logic              accept, key_ld, pt_ld, key_clr;
    logic [WCNT_W-1:0] key_cnt, pt_cnt, out_cnt;
    logic              key_wrap, pt_wrap;
    logic [BLK_W-1:0]  pt_blk;
    logic              key_valid, pt_full;
    logic [SCNT_W-1:0] settle_cnt;
    logic [BLK_W-1:0]  res_reg;
    logic              launch, capture, take;

    // Once a plaintext block is held, only key words may enter.
    assign in_ready = (state == COLLECT) && !(pt_full && !key_load);
    assign accept   = in_valid && in_ready;
    assign key_ld   = accept && key_load;
    assign pt_ld    = accept && !key_load;
    assign key_clr  = key_ld && (key_cnt == '0);

    ece571f23_g5_aes_wordpacker u_key_pack (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (key_ld),
        .data   (in_data),
        .block  (key),
        .cnt    (key_cnt),
        .wrap_c (key_wrap)
    );

    ece571f23_g5_aes_wordpacker u_pt_pack (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (pt_ld),
        .data   (in_data),
        .block  (pt_blk),
        .cnt    (pt_cnt),
        .wrap_c (pt_wrap)
    );

    // Next-state and one-cycle strobes.
    always_comb begin
        state_n = state;
        launch  = 1'b0;
        capture = 1'b0;
        take    = 1'b0;
        unique case (state)
            COLLECT: begin
                // A key word landing this cycle may be the start of a reload, so hold off.
                if (pt_full && key_valid && !key_ld) begin
                    launch  = 1'b1;
                    state_n = SETTLE;
                end
            end
            SETTLE: begin
                if (settle_cnt == '0) begin
                    capture = 1'b1;
                    state_n = DRAIN;
                end
            end
            DRAIN: begin
                if (out_valid && out_ready) begin
                    take = 1'b1;
                    if (out_cnt == WCNT_W'(BLK_WORDS - 1)) begin
                        state_n = COLLECT;
                    end
                end
            end
            default: state_n = COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= COLLECT;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
            settle_cnt <= '0;
            key_valid  <= 1'b0;
            pt_full    <= 1'b0;
            res_reg    <= '0;
            out_cnt    <= '0;
        end else begin
            state     <= state_n;
            out_valid <= (state_n == DRAIN);
            busy      <= (state_n != COLLECT);

            if (launch) begin
                settle_cnt <= SCNT_W'(SETTLE_CYCLES - 1);
            end else if ((state == SETTLE) && (settle_cnt != '0)) begin
                settle_cnt <= settle_cnt - SCNT_W'(1);
            end

            if (key_clr) begin
                key_valid <= 1'b0;
            end else if (key_wrap) begin
                key_valid <= 1'b1;
            end

            if (pt_wrap) begin
                pt_full <= 1'b1;
            end else if (capture) begin
                pt_full <= 1'b0;
            end

            // Result is shifted up so the word on offer always sits in the top slot.
            if (capture) begin
                res_reg <= cipher;
                out_cnt <= '0;
            end else if (take) begin
                res_reg <= {res_reg[BLK_W-WORD_W-1:0], WORD_W'(0)};
                out_cnt <= out_cnt + WCNT_W'(1);
            end
        end
    end

    assign out_data = res_reg[BLK_W-1:BLK_W-WORD_W];

`ifdef AES_LOADER_CBC_EN
    logic [BLK_W-1:0] chain;

    // Starting a new key restarts the chain from a zero IV.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
        end else if (key_clr) begin
            chain <= '0;
        end else if (capture) begin
            chain <= cipher;
        end
    end

    assign plaintext = pt_blk ^ chain;
`else
    assign plaintext = pt_blk;
`endif

endmodule

// File: tb/tb_ece571f23_g5_aes_loader.sv
// Directed bench for the AES loader with a behavioural cipher stand-in that
// only produces a valid result once its inputs have been stable long enough.
module tb_ece571f23_g5_aes_loader;

    localparam int unsigned SETTLE = 2;
    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] JUNK = 128'hdeadbeefdeadbeefdeadbeefdeadbeef;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, in_ready, key_load, out_valid, out_ready, busy;
    logic [31:0]  in_data, out_data;
    logic [127:0] plaintext, key, cipher;

    int unsigned  cyc = 0;
    int unsigned  last_acc = 0;
    int           stab = 0;
    logic [127:0] last_k = '0, last_p = '0;
    int           errors = 0;
    int           checks = 0;

    ece571f23_g5_aes_loader #(.SETTLE_CYCLES(SETTLE)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .key_load  (key_load),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .plaintext (plaintext),
        .key       (key),
        .cipher    (cipher),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Known FIPS-197 C.1 answer; any other input gets an arbitrary but fixed mix.
    function automatic logic [127:0] model(input logic [127:0] k, input logic [127:0] p);
        if (k == K1 && p == P1) return C1;
        return k ^ {p[95:0], p[127:96]} ^ 128'h5a5a5a5a_a5a5a5a5_5a5a5a5a_a5a5a5a5;
    endfunction

    // Cipher output is garbage until key/plaintext have been stable for SETTLE edges.
    always @(negedge clk) begin
        if (key !== last_k || plaintext !== last_p) begin
            stab   <= 0;
            last_k <= key;
            last_p <= plaintext;
        end else if (stab < 15) begin
            stab <= stab + 1;
        end
    end
    assign cipher = (stab >= int'(SETTLE)) ? model(key, plaintext) : JUNK;

    function automatic logic [31:0] wd(input logic [127:0] b, input int i);
        return b[127-32*i -: 32];
    endfunction

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Drive one word from a negedge; returns at the negedge after acceptance.
    task automatic send(input logic kl, input logic [31:0] d);
        int n = 0;
        in_valid = 1'b1;
        key_load = kl;
        in_data  = d;
        #1;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!in_ready) chk("send_timeout", 128'(in_ready), 128'(1'b1));
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        last_acc = cyc;
    endtask

    // Receive four words, checking latency, optional backpressure hold, and order.
    task automatic recv(input logic [127:0] exp, input int bp);
        int n = 0;
        out_ready = (bp == 0);
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) begin
            chk("out_timeout", 128'(out_valid), 128'(1'b1));
            return;
        end
        chk("latency", 128'(cyc - last_acc), 128'(SETTLE + 1));
        for (int i = 0; i < bp; i++) begin
            chk("bp_data", 128'(out_data), 128'(wd(exp, 0)));
            chk("bp_in_ready", 128'(in_ready), 128'(1'b0));
            chk("bp_busy", 128'(busy), 128'(1'b1));
            @(negedge clk);
        end
        out_ready = 1'b1;
        for (int w = 0; w < 4; w++) begin
            chk($sformatf("valid_w%0d", w), 128'(out_valid), 128'(1'b1));
            chk($sformatf("data_w%0d", w), 128'(out_data), 128'(wd(exp, w)));
            @(posedge clk);
            @(negedge clk);
        end
        chk("drain_valid", 128'(out_valid), 128'(1'b0));
        chk("drain_busy", 128'(busy), 128'(1'b0));
        out_ready = 1'b0;
    endtask

    initial begin
        logic [127:0] exp2;
`ifdef AES_LOADER_CBC_EN
        exp2 = model(K1, P1 ^ C1);
`else
        exp2 = C1;
`endif
        rst_n = 1'b0;
        in_valid = 1'b0;
        key_load = 1'b0;
        in_data = '0;
        out_ready = 1'b0;
        #12;
        chk("rst_out_valid", 128'(out_valid), 128'(1'b0));
        chk("rst_busy", 128'(busy), 128'(1'b0));
        chk("rst_key", key, 128'h0);
        chk("rst_pt", plaintext, 128'h0);
        chk("rst_out_data", 128'(out_data), 128'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("idle_in_ready", 128'(in_ready), 128'(1'b1));

        // FIPS-197 C.1: key first, then plaintext
        for (int i = 0; i < 4; i++) send(1'b1, wd(K1, i));
        for (int i = 0; i < 4; i++) send(1'b0, wd(P1, i));
        chk("key_bus", key, K1);
        chk("pt_bus", plaintext, P1);
        recv(C1, 0);

        // Second block, same key, with 10 cycles of output backpressure
        for (int i = 0; i < 4; i++) send(1'b0, wd(P1, i));
        recv(exp2, 10);

        // Interleaved key reload and plaintext
        for (int i = 0; i < 4; i++) begin
            send(1'b1, wd(K1, i));
            send(1'b0, wd(P1, i));
        end
        recv(C1, 0);

        // Reset while settling
        for (int i = 0; i < 4; i++) send(1'b0, wd(P1, i));
        @(negedge clk);
        chk("settle_busy", 128'(busy), 128'(1'b1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 128'(out_valid), 128'(1'b0));
        chk("mid_rst_busy", 128'(busy), 128'(1'b0));
        chk("mid_rst_pt", plaintext, 128'h0);
        chk("mid_rst_key", key, 128'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Plaintext before key: fifth plaintext word refused, no launch until key completes
        for (int i = 0; i < 4; i++) send(1'b0, wd(P1, i));
        in_valid = 1'b1;
        key_load = 1'b0;
        in_data  = 32'h12345678;
        #1;
        chk("pt5_blocked", 128'(in_ready), 128'(1'b0));
        repeat (3) @(negedge clk);
        chk("no_key_idle", 128'(busy), 128'(1'b0));
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) send(1'b1, wd(K1, i));
        @(negedge clk);
        chk("partial_key_idle", 128'(busy), 128'(1'b0));
        send(1'b1, wd(K1, 3));
        recv(C1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
